// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage: datapath width, the NOP
// encoding and the fetch FSM state type.
package inst_fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: one memory request per fetch_req,
// the response is held for decode until accepted; flush discards work in flight.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; a raised valid and its payload stay stable until that transfer. The
// memory response channel has no ready and is consumed the cycle it arrives.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST    = NOP_WORD,
  parameter bit              ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_req,
  input  logic            flush,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault,
  output fetch_state_e    dbg_state
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            req_valid_q;
  logic            inst_valid_q;
  logic            fault_q;
  logic            misaligned;

  assign misaligned = ALIGN_CHECK && (fetch_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc_q         <= '0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_req && !flush) begin
            pc_q <= fetch_pc;
            if (misaligned) begin
              // Fault is reported through the normal HOLD handshake with a NOP.
              state        <= S_HOLD;
              inst_q       <= NOP_INST;
              inst_pc_q    <= fetch_pc;
              inst_valid_q <= 1'b1;
              fault_q      <= 1'b1;
            end else begin
              state       <= S_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            // An accepted request always has a response coming back.
            req_valid_q <= 1'b0;
            state       <= flush ? S_DROP : S_WAIT;
          end else if (flush) begin
            req_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state <= mem_resp_valid ? S_IDLE : S_DROP;
          end else if (mem_resp_valid) begin
            inst_q       <= mem_resp_data;
            inst_pc_q    <= pc_q;
            inst_valid_q <= 1'b1;
            state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready || flush) begin
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_DROP: begin
          if (mem_resp_valid) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state        <= S_IDLE;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          inst_q       <= NOP_INST;
          fault_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = pc_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign fetch_fault   = fault_q;
  assign dbg_state     = state;

endmodule
